// File: rtl/ma_level_detector.sv
// Level detector on the moving-average output: hysteresis + debounce, rise/fall pulses, peaks, rise-event count.
// Latency: level_high and pulses update 1 clk after the committing sample_valid edge.
// Backpressure: none, one sample may be accepted every cycle. Optional timestamp via LVL_DET_TIMESTAMP_EN.
module ma_level_detector #(
  parameter int DW    = 16,
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic signed [DW-1:0]    sample,
  input  logic signed [DW-1:0]    thr_high,
  input  logic signed [DW-1:0]    thr_low,
  input  logic [CNT_W-1:0]        debounce,
  input  logic                    clear,
  output logic                    level_high,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic signed [DW-1:0]    peak_max,
  output logic signed [DW-1:0]    peak_min,
  output logic [EVT_W-1:0]        rise_count,
  output logic [31:0]             last_evt_ts
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_PEND = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_PEND = 2'd3
  } state_t;

  localparam logic signed [DW-1:0] PEAK_MAX_RST = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] PEAK_MIN_RST = {1'b0, {(DW-1){1'b1}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             rise_commit, fall_commit;

  logic             valid_en;
  logic             rise_qual, fall_qual;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W:0]   run_inc;
  logic             run_hit;
  logic [CNT_W-1:0] run_sat;

  assign valid_en  = enable && sample_valid;
  assign rise_qual = sample > thr_high;
  assign fall_qual = sample < thr_low;
  // A debounce setting of zero behaves like one: a single sample commits.
  assign n_eff     = (debounce == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : debounce;
  // Widened by one bit so the commit compare cannot alias on a full counter.
  assign run_inc   = {1'b0, run_q} + {{CNT_W{1'b0}}, 1'b1};
  assign run_hit   = (run_inc == {1'b0, n_eff});
  assign run_sat   = (&run_q) ? run_q : run_inc[CNT_W-1:0];

  // State and run counter register; reset drops any pending run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state: only qualified samples advance or break a run.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    rise_commit = 1'b0;
    fall_commit = 1'b0;
    if (valid_en) begin
      case (state_q)
        S_LOW, S_RISE_PEND: begin
          if (rise_qual) begin
            if (run_hit) begin
              state_d     = S_HIGH;
              run_d       = '0;
              rise_commit = 1'b1;
            end else begin
              state_d = S_RISE_PEND;
              run_d   = run_sat;
            end
          end else begin
            state_d = S_LOW;
            run_d   = '0;
          end
        end
        default: begin
          if (fall_qual) begin
            if (run_hit) begin
              state_d     = S_LOW;
              run_d       = '0;
              fall_commit = 1'b1;
            end else begin
              state_d = S_FALL_PEND;
              run_d   = run_sat;
            end
          end else begin
            state_d = S_HIGH;
            run_d   = '0;
          end
        end
      endcase
    end
  end

  // Output decode: a pending fall is still HIGH, a pending rise is still LOW.
  always_comb begin
    level_high = (state_q == S_HIGH) || (state_q == S_FALL_PEND);
  end

  // Event pulses are registered commits, so they last exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_commit;
      fall_pulse <= fall_commit;
    end
  end

  // Peak tracking and saturating rise counter; clear wins but still absorbs a same-cycle sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_max   <= PEAK_MAX_RST;
      peak_min   <= PEAK_MIN_RST;
      rise_count <= '0;
    end else if (clear) begin
      if (valid_en) begin
        peak_max   <= sample;
        peak_min   <= sample;
        rise_count <= {{(EVT_W-1){1'b0}}, rise_commit};
      end else begin
        peak_max   <= PEAK_MAX_RST;
        peak_min   <= PEAK_MIN_RST;
        rise_count <= '0;
      end
    end else if (valid_en) begin
      if (sample > peak_max) peak_max <= sample;
      if (sample < peak_min) peak_min <= sample;
      if (rise_commit && !(&rise_count)) rise_count <= rise_count + 1'b1;
    end
  end

`ifdef LVL_DET_TIMESTAMP_EN
  logic [31:0] cyc_q;

  // Free-running cycle counter; ignores enable and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 32'd1;
  end

  // Capture the counter value seen on the committing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          last_evt_ts <= '0;
    else if (rise_commit || fall_commit) last_evt_ts <= cyc_q;
  end
`else
  assign last_evt_ts = 32'd0;
`endif

endmodule

// File: tb/tb_ma_level_detector.sv
// Directed bench for ma_level_detector with a scoreboard of expected post-edge outputs.
// Each step pushes the model's expectation, clocks the DUT once, then pops and compares.
// Timestamps are checked against a bench-side cycle count when LVL_DET_TIMESTAMP_EN is set.
module tb_ma_level_detector;
  localparam int DW    = 16;
  localparam int CNT_W = 4;
  localparam int EVT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] sample = '0;
  logic signed [DW-1:0] thr_high = '0;
  logic signed [DW-1:0] thr_low = '0;
  logic [CNT_W-1:0]     debounce = '0;
  logic                 clear = 1'b0;
  logic                 level_high, rise_pulse, fall_pulse;
  logic signed [DW-1:0] peak_max, peak_min;
  logic [EVT_W-1:0]     rise_count;
  logic [31:0]          last_evt_ts;

  ma_level_detector #(.DW(DW), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample(sample), .thr_high(thr_high), .thr_low(thr_low), .debounce(debounce),
    .clear(clear), .level_high(level_high), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .peak_max(peak_max), .peak_min(peak_min),
    .rise_count(rise_count), .last_evt_ts(last_evt_ts)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  typedef struct packed {
    logic             lvl;
    logic             rp;
    logic             fp;
    logic [DW-1:0]    mx;
    logic [DW-1:0]    mn;
    logic [EVT_W-1:0] cnt;
    logic [31:0]      ts;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Behavioural model state
  bit          m_lvl;
  int          m_run, m_max, m_min, m_cnt;
  logic [31:0] m_ts;

  task automatic model_reset();
    m_lvl = 1'b0; m_run = 0; m_max = -32768; m_min = 32767; m_cnt = 0; m_ts = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit vld, input int s, input bit clr, input bit en);
    int   n;
    bit   rq, fq, rise, fall;
    exp_t e, got;
    n    = (debounce == '0) ? 1 : int'(debounce);
    rq   = s > int'(thr_high);
    fq   = s < int'(thr_low);
    rise = 1'b0;
    fall = 1'b0;
    if (vld && en) begin
      if (!m_lvl) begin
        if (rq) begin
          if (m_run + 1 == n) begin m_lvl = 1'b1; m_run = 0; rise = 1'b1; end
          else m_run = (m_run + 1 > 15) ? 15 : m_run + 1;
        end else m_run = 0;
      end else begin
        if (fq) begin
          if (m_run + 1 == n) begin m_lvl = 1'b0; m_run = 0; fall = 1'b1; end
          else m_run = (m_run + 1 > 15) ? 15 : m_run + 1;
        end else m_run = 0;
      end
    end
    if (clr) begin
      if (vld && en) begin m_max = s; m_min = s; m_cnt = rise ? 1 : 0; end
      else begin m_max = -32768; m_min = 32767; m_cnt = 0; end
    end else if (vld && en) begin
      if (s > m_max) m_max = s;
      if (s < m_min) m_min = s;
      if (rise && m_cnt < 255) m_cnt++;
    end
`ifdef LVL_DET_TIMESTAMP_EN
    if (rise || fall) m_ts = tb_cyc;
`endif
    e.lvl = m_lvl; e.rp = rise; e.fp = fall;
    e.mx = m_max[DW-1:0]; e.mn = m_min[DW-1:0];
    e.cnt = m_cnt[EVT_W-1:0]; e.ts = m_ts;
    sb.push_back(e);
    sample_valid = vld; sample = s[DW-1:0]; clear = clr; enable = en;
    @(posedge clk);
    #1;
    sample_valid = 1'b0; clear = 1'b0; enable = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("level_high", {31'd0, level_high}, {31'd0, got.lvl});
      chk("rise_pulse", {31'd0, rise_pulse}, {31'd0, got.rp});
      chk("fall_pulse", {31'd0, fall_pulse}, {31'd0, got.fp});
      chk("peak_max",   {16'd0, peak_max},   {16'd0, got.mx});
      chk("peak_min",   {16'd0, peak_min},   {16'd0, got.mn});
      chk("rise_count", {24'd0, rise_count}, {24'd0, got.cnt});
      chk("last_evt_ts", last_evt_ts, got.ts);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    thr_high = 16'sd100; thr_low = 16'sd50; debounce = 4'd3;
    #12;
    // Values held during reset
    chk("rst_level", {31'd0, level_high}, 32'd0);
    chk("rst_rise",  {31'd0, rise_pulse}, 32'd0);
    chk("rst_fall",  {31'd0, fall_pulse}, 32'd0);
    chk("rst_max",   {16'd0, peak_max}, 32'h0000_8000);
    chk("rst_min",   {16'd0, peak_min}, 32'h0000_7fff);
    chk("rst_count", {24'd0, rise_count}, 32'd0);
    chk("rst_ts",    last_evt_ts, 32'd0);
    model_reset();
    rst_n = 1'b1; enable = 1'b1;
    @(posedge clk); #1;

    // Three qualifying samples commit HIGH on the third
    step(1, 120, 0, 1); step(1, 120, 0, 1); step(1, 120, 0, 1);
    chk("rise_after_3", {31'd0, rise_pulse}, 32'd1);
    chk("count_after_rise", {24'd0, rise_count}, 32'd1);
    idle(1);
    chk("pulse_one_clk", {31'd0, rise_pulse}, 32'd0);

    // Between-threshold samples keep HIGH, then three lows fall
    step(1, 80, 0, 1); step(1, 70, 0, 1);
    step(1, 40, 0, 1); step(1, 40, 0, 1);
    chk("no_fall_yet", {31'd0, level_high}, 32'd1);
    step(1, 40, 0, 1);
    chk("fall_after_3", {31'd0, fall_pulse}, 32'd1);
    chk("low_after_fall", {31'd0, level_high}, 32'd0);

    // Broken run returns to LOW and restarts
    step(1, 120, 0, 1); step(1, 120, 0, 1); step(1, 80, 0, 1); step(1, 120, 0, 1);
    chk("broken_run_low", {31'd0, level_high}, 32'd0);
    step(1, 10, 0, 1);

    // Idle gaps inside a run neither advance nor break it
    step(1, 120, 0, 1); idle(2); step(1, 120, 0, 1); idle(3); step(1, 120, 0, 1);
    step(1, 10, 0, 1); step(1, 10, 0, 1); step(1, 10, 0, 1);

    // Debounce 0 acts as 1, with 5 clk gaps
    debounce = 4'd0;
    step(1, 200, 0, 1); idle(5); step(1, 10, 0, 1); idle(5);
    chk("deb0_low", {31'd0, level_high}, 32'd0);

    // enable low holds state; clear still honoured
    debounce = 4'd1;
    step(1, 200, 0, 0);
    step(0, 0, 1, 0);
    chk("clear_alone_max", {16'd0, peak_max}, 32'h0000_8000);

    // Peak tracking and clear with same-cycle sample
    step(1, -300, 0, 1); step(1, 500, 0, 1);
    chk("peak_min_m300", {16'd0, peak_min}, 32'h0000_fed4);
    chk("peak_max_500",  {16'd0, peak_max}, 32'h0000_01f4);
    step(1, 7, 1, 1);
    chk("clr_min_7", {16'd0, peak_min}, 32'd7);
    step(1, 10, 0, 1);

    // Clear with a rising commit restarts the count at 1
    step(1, 200, 1, 1);
    step(1, 10, 0, 1);

    // Misordered thresholds: 75 is both above thr_high and below thr_low
    thr_high = 16'sd50; thr_low = 16'sd100;
    step(1, 75, 0, 1); step(1, 75, 0, 1);
    thr_high = 16'sd100; thr_low = 16'sd50;

    // Async reset mid-run drops the pending run without a pulse
    debounce = 4'd3;
    step(1, 120, 0, 1); step(1, 120, 0, 1);
    rst_n = 1'b0; model_reset(); sb.delete();
    #3;
    chk("midrst_level", {31'd0, level_high}, 32'd0);
    chk("midrst_rise",  {31'd0, rise_pulse}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 120, 0, 1);
    chk("midrst_no_rise", {31'd0, rise_pulse}, 32'd0);
    step(1, 10, 0, 1);

    // 256 rise/fall cycles saturate the event counter
    debounce = 4'd1;
    for (int i = 0; i < 256; i++) begin
      step(1, 200, 0, 1);
      step(1, 10, 0, 1);
    end
    chk("count_saturated", {24'd0, rise_count}, 32'd255);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
